// File: rtl/switch_cmd_encoder_pkg.sv
// Shared definitions for the switch command encoder: channel tags, the
// ignore/out-of-range selection encoding and command field offsets.
package switch_cmd_encoder_pkg;

  // Channel tags carried in the command LSBs.
  typedef enum logic [1:0] {
    CHAN_NONE      = 2'b00,
    CHAN_AUX       = 2'b01,
    CHAN_TRAVELLER = 2'b10,
    CHAN_TARGET    = 2'b11
  } chan_e;

  localparam int unsigned CHAN_W_DEF = 32'd2;

  // Selection field value used when the switch value is ignored / out of range.
  localparam int unsigned SEL_IGNORE = 32'd0;

  // Command layout, LSB first: {flag, sel_field, channel}.
  localparam int unsigned CMD_CHAN_LSB = 32'd0;

  // LSB position of the selection field.
  function automatic int unsigned cmd_sel_lsb(input int unsigned chan_w);
    return chan_w;
  endfunction

  // Position of the reserved top flag bit (always zero).
  function automatic int unsigned cmd_flag_bit(input int unsigned sel_w,
                                               input int unsigned chan_w);
    return sel_w + chan_w;
  endfunction

endpackage

// File: rtl/switch_cmd_encoder_debouncer.sv
// switch_debouncer: two-flop synchroniser plus a saturating stability counter.
// Emits a one-cycle strobe with the synchronised value once it has been equal
// for DEBOUNCE_CNT consecutive cycles.
module switch_debouncer #(
  parameter int unsigned SEL_W        = 32'd5,
  parameter int unsigned DEBOUNCE_CNT = 32'd500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sw_i,
  output logic [SEL_W-1:0] stable_o,
  output logic             stable_stb_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_STB  = CNT_W'(DEBOUNCE_CNT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  logic [SEL_W-1:0] sync1_q;
  logic [SEL_W-1:0] sync2_q;
  logic [SEL_W-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SEL_W-1:0] stable_q;
  logic             stb_q;
  logic             stb_d;

  // Synchronise the raw switches and remember the previous synchronised value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {SEL_W{1'b0}};
      sync2_q <= {SEL_W{1'b0}};
      prev_q  <= {SEL_W{1'b0}};
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Restart the count on any change, otherwise count up to saturation; strobe on reaching DEBOUNCE_CNT-1.
  always_comb begin
    cnt_d = cnt_q;
    stb_d = 1'b0;
    if (sync2_q != prev_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    if ((cnt_d == CNT_STB) && (cnt_q != CNT_STB)) begin
      stb_d = 1'b1;
    end else begin
      stb_d = 1'b0;
    end
  end

  // Counter, strobe and captured stable value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= CNT_ZERO;
      stb_q    <= 1'b0;
      stable_q <= {SEL_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
      if (stb_d) begin
        stable_q <= sync2_q;
      end
    end
  end

  assign stable_o     = stable_q;
  assign stable_stb_o = stb_q;

endmodule

// File: rtl/switch_cmd_encoder.sv
// switch_cmd_encoder: debounces a switch bank, range-checks the stable value
// and issues a channel-tagged command byte over valid/ready once per change.
// Optional feature macro: SWITCH_CMD_AUTO_REPEAT_EN (periodic re-issue of the
// committed command every REPEAT_CNT cycles).
module switch_cmd_encoder
  import switch_cmd_encoder_pkg::*;
#(
  parameter int unsigned          SEL_W        = 32'd5,
  parameter int unsigned          CHAN_W       = CHAN_W_DEF,
  parameter logic [CHAN_W-1:0]    CHANNEL      = CHAN_TARGET,
  parameter int unsigned          SEL_MAX      = 32'd20,
  parameter int unsigned          DEBOUNCE_CNT = 32'd500000,
`ifdef SWITCH_CMD_AUTO_REPEAT_EN
  parameter int unsigned          REPEAT_CNT   = 32'd25000000,
`endif
  localparam int unsigned         DATA_W       = 32'd1 + SEL_W + CHAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  select_switches_i,
  input  logic              cmd_ready_i,
  input  logic              clear_overflow_i,
  output logic [DATA_W-1:0] cmd_data_o,
  output logic              cmd_valid_o,
  output logic              out_of_range_o,
  output logic              overflow_o
);

  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(SEL_IGNORE);

  logic [SEL_W-1:0]  stable_s;
  logic              stb_s;
  logic              commit_s;
  logic              repeat_s;
  logic              load_s;
  logic              xfer_s;
  logic [SEL_W-1:0]  load_val_s;
  logic              load_oor_s;
  logic [SEL_W-1:0]  sel_field_s;

  logic [SEL_W-1:0]  cmt_val_q;
  logic              cmt_vld_q;
  logic [DATA_W-1:0] cmd_data_q;
  logic [DATA_W-1:0] cmd_data_d;
  logic              cmd_valid_q;
  logic              cmd_valid_d;
  logic              oor_q;
  logic              oor_d;
  logic              ovf_q;
  logic              ovf_d;

  switch_debouncer #(
    .SEL_W        (SEL_W),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debouncer (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_i         (select_switches_i),
    .stable_o     (stable_s),
    .stable_stb_o (stb_s)
  );

`ifdef SWITCH_CMD_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CNT > 32'd1) ? $clog2(REPEAT_CNT) : 32'd1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CNT - 32'd1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(32'd1);
  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_d;

  // Repeat timer: restarts on every commit or repeat, fires after REPEAT_CNT cycles.
  always_comb begin
    repeat_s  = 1'b0;
    rpt_cnt_d = rpt_cnt_q;
    if (cmt_vld_q && !commit_s && (rpt_cnt_q == RPT_LAST)) begin
      repeat_s = 1'b1;
    end else begin
      repeat_s = 1'b0;
    end
    if (commit_s || repeat_s) begin
      rpt_cnt_d = {RPT_W{1'b0}};
    end else if (cmt_vld_q) begin
      rpt_cnt_d = rpt_cnt_q + RPT_ONE;
    end else begin
      rpt_cnt_d = rpt_cnt_q;
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q <= {RPT_W{1'b0}};
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  // Decide whether a new or repeated command is loaded and build its word.
  always_comb begin
    commit_s = stb_s && (!cmt_vld_q || (stable_s != cmt_val_q));
    load_s   = commit_s || repeat_s;
    xfer_s   = cmd_valid_q && cmd_ready_i;
    if (commit_s) begin
      load_val_s = stable_s;
    end else begin
      load_val_s = cmt_val_q;
    end
    load_oor_s = (32'(load_val_s) > SEL_MAX);
    if (load_oor_s) begin
      sel_field_s = SEL_ZERO;
    end else begin
      sel_field_s = load_val_s;
    end
  end

  // Next-state for the command word, valid, range flag and sticky overflow.
  always_comb begin
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    oor_d       = oor_q;
    ovf_d       = ovf_q;
    if (load_s) begin
      cmd_data_d  = {1'b0, sel_field_s, CHANNEL};
      cmd_valid_d = 1'b1;
      oor_d       = load_oor_s;
    end else if (xfer_s) begin
      cmd_valid_d = 1'b0;
    end else begin
      cmd_valid_d = cmd_valid_q;
    end
    if (load_s && cmd_valid_q && !cmd_ready_i) begin
      ovf_d = 1'b1;
    end else if (clear_overflow_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Output and committed-value registers; "none committed" after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmt_val_q   <= {SEL_W{1'b0}};
      cmt_vld_q   <= 1'b0;
      cmd_data_q  <= {1'b0, SEL_ZERO, CHANNEL};
      cmd_valid_q <= 1'b0;
      oor_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (commit_s) begin
        cmt_val_q <= stable_s;
        cmt_vld_q <= 1'b1;
      end
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      oor_q       <= oor_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cmd_data_o     = cmd_data_q;
  assign cmd_valid_o    = cmd_valid_q;
  assign out_of_range_o = oor_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_switch_cmd_encoder.sv
// Directed bench for switch_cmd_encoder with DEBOUNCE_CNT=4.
module tb_switch_cmd_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sw;
  logic       ready;
  logic       clr;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       oor;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cnt = 0;
  logic [7:0] last_xfer = 8'h00;

  switch_cmd_encoder #(
    .SEL_W        (5),
    .CHAN_W       (2),
    .CHANNEL      (2'b11),
    .SEL_MAX      (20),
    .DEBOUNCE_CNT (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .select_switches_i (sw),
    .cmd_ready_i       (ready),
    .clear_overflow_i  (clr),
    .cmd_data_o        (cmd_data),
    .cmd_valid_o       (cmd_valid),
    .out_of_range_o    (oor),
    .overflow_o        (ovf)
  );

  always #5 clk = ~clk;

  // Record transfers (valid & ready) midway through each cycle.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && ready) begin
      xfer_cnt  = xfer_cnt + 1;
      last_xfer = cmd_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = 0;
    while (!cmd_valid && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  int first;
  int vcnt;
  int x0;
  int cyc;

  initial begin
    rst_n = 1'b0;
    sw    = 5'd7;
    ready = 1'b1;
    clr   = 1'b0;
    #22;
    check("rst_data", cmd_data, 8'h03);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_oor", oor, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    // First stable value after reset: one pulse at cycle 7.
    first = 0;
    vcnt  = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (cmd_valid) begin
        vcnt++;
        if (first == 0) first = i;
      end
    end
    check("t1_latency", first, 7);
    check("t1_pulses", vcnt, 1);
    check("t1_xfers", xfer_cnt, 1);
    check("t1_data", last_xfer, 8'h1F);

    // Bounce 7->9->7->9 then steady 9.
    x0 = xfer_cnt;
    sw = 5'd9; tick();
    sw = 5'd7; tick();
    sw = 5'd9;
    repeat (20) tick();
    check("t2_xfers", xfer_cnt - x0, 1);
    check("t2_data", last_xfer, 8'h27);

    // Out of range, then the largest legal value.
    sw = 5'd25;
    repeat (12) tick();
    check("t3_oor_data", last_xfer, 8'h03);
    check("t3_oor_flag", oor, 1'b1);
    sw = 5'd20;
    repeat (12) tick();
    check("t3_max_data", last_xfer, 8'h53);
    check("t3_max_flag", oor, 1'b0);
    check("t3_xfers", xfer_cnt - x0, 3);

    // Overwrite while stalled sets overflow; clear; then one transfer.
    ready = 1'b0;
    sw = 5'd3;
    repeat (10) tick();
    check("t4_valid", cmd_valid, 1'b1);
    check("t4_data3", cmd_data, 8'h0F);
    check("t4_ovf0", ovf, 1'b0);
    sw = 5'd4;
    repeat (10) tick();
    check("t4_data4", cmd_data, 8'h13);
    check("t4_ovf1", ovf, 1'b1);
    clr = 1'b1; tick();
    clr = 1'b0;
    check("t4_ovf_clr", ovf, 1'b0);
    x0 = xfer_cnt;
    ready = 1'b1;
    repeat (5) tick();
    check("t4_xfers", xfer_cnt - x0, 1);
    check("t4_xdata", last_xfer, 8'h13);
    check("t4_valid_low", cmd_valid, 1'b0);

    // Commit in the same cycle as an accepted transfer.
    ready = 1'b0;
    sw = 5'd10;
    wait_valid(20, cyc);
    check("t5_pend", cmd_data, 8'h2B);
    sw = 5'd11;
    repeat (6) tick();
    check("t5_still_pend", cmd_data, 8'h2B);
    ready = 1'b1;
    tick();
    check("t5_valid", cmd_valid, 1'b1);
    check("t5_data", cmd_data, 8'h2F);
    check("t5_ovf", ovf, 1'b0);
    check("t5_xdata_old", last_xfer, 8'h2B);
    tick();
    check("t5_xdata_new", last_xfer, 8'h2F);
    check("t5_valid_low", cmd_valid, 1'b0);

    // Reset mid-debounce.
    ready = 1'b0;
    sw = 5'd12;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6a_data", cmd_data, 8'h03);
    check("t6a_valid", cmd_valid, 1'b0);
    #2 rst_n = 1'b1;
    wait_valid(20, cyc);
    check("t6a_latency", cyc, 7);
    check("t6a_redata", cmd_data, 8'h33);

    // Reset while a command is pending; same value re-emits.
    #2 rst_n = 1'b0;
    #1;
    check("t6b_data", cmd_data, 8'h03);
    check("t6b_valid", cmd_valid, 1'b0);
    check("t6b_oor", oor, 1'b0);
    check("t6b_ovf", ovf, 1'b0);
    #2 rst_n = 1'b1;
    wait_valid(20, cyc);
    check("t6b_latency", cyc, 7);
    check("t6b_redata", cmd_data, 8'h33);
    ready = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
